// File: rtl/db9md_pad_scan.sv
`timescale 1ns/1ps
// db9md_pad_scan: time-multiplexed scanner for two Megadrive (3/6-button) pads
// sharing one DB9 bus through an external mux; publishes button vectors once per frame.

module db9md_pad_scan #(
  parameter int HALF_CLKS   = 150,
  parameter int IDLE_PHASES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_present,
  output logic [1:0]  six_btn,
  output logic        frame_done
);

  localparam int HW = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam int IW = (IDLE_PHASES > 1) ? $clog2(IDLE_PHASES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CLKS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_PHASES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [HW-1:0]   r_halfCnt;
  logic [HW-1:0]   w_halfCntNext;
  logic            r_second;
  logic            w_secondNext;
  logic [2:0]      r_phase;
  logic [2:0]      w_phaseNext;
  logic [IW-1:0]   r_idleCnt;
  logic [IW-1:0]   w_idleCntNext;
  logic            w_halfEnd;
  logic            w_frameEnd;

  logic [5:0]      r_sync1;
  logic [5:0]      r_sync2;
  logic [5:0]      w_act;
  logic            w_pad;

  logic [1:0][11:0] r_shadow;
  logic [1:0]       r_present;
  logic [1:0]       r_six;

  logic [15:0]     r_joy1;
  logic [15:0]     r_joy2;
  logic [1:0]      r_presentOut;
  logic [1:0]      r_sixOut;
  logic            r_frameDone;
  logic            r_mdsel;
  logic            r_split;

  assign w_halfEnd = (r_halfCnt == HALF_LAST);
  assign w_act     = ~r_sync2;
  assign w_pad     = r_second;

  // The DB9 lines are asynchronous to clk_sys; idle level of the bus is all-high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 6'b111111;
      r_sync2 <= 6'b111111;
    end else begin
      r_sync1 <= joy_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_halfCntNext = r_halfCnt + 1'b1;
    w_secondNext  = r_second;
    w_phaseNext   = r_phase;
    w_idleCntNext = r_idleCnt;
    w_frameEnd    = 1'b0;
    if (w_halfEnd) begin
      w_halfCntNext = '0;
      w_secondNext  = ~r_second;
      if (r_second) begin
        case (r_state)
          IDLE: begin
            if (r_idleCnt == IDLE_LAST) begin
              w_idleCntNext = '0;
              w_phaseNext   = 3'd0;
              w_stateNext   = SCAN;
            end else begin
              w_idleCntNext = r_idleCnt + 1'b1;
            end
          end
          SCAN: begin
            if (r_phase == 3'd7) begin
              w_phaseNext = 3'd0;
              w_stateNext = IDLE;
              w_frameEnd  = 1'b1;
            end else begin
              w_phaseNext = r_phase + 3'd1;
            end
          end
          default: begin
            w_stateNext = IDLE;
          end
        endcase
      end
    end
  end

  // Select lines are registered from the next-state values so they never glitch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_halfCnt <= '0;
      r_second  <= 1'b0;
      r_phase   <= 3'd0;
      r_idleCnt <= '0;
      r_mdsel   <= 1'b1;
      r_split   <= 1'b1;
    end else begin
      r_halfCnt <= w_halfCntNext;
      r_second  <= w_secondNext;
      r_phase   <= w_phaseNext;
      r_idleCnt <= w_idleCntNext;
      r_mdsel   <= (w_stateNext == IDLE) || !w_phaseNext[0];
      r_split   <= (w_stateNext == IDLE) || !w_secondNext;
    end
  end

  // Each pad is sampled on the last cycle of its half, long after the mux settled.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_present <= '0;
      r_six     <= '0;
    end else if ((r_state == SCAN) && w_halfEnd) begin
      case (r_phase)
        3'd0: begin
          r_shadow[w_pad][5:0] <= {w_act[5], w_act[4], w_act[0], w_act[1], w_act[2], w_act[3]};
        end
        3'd1: begin
          r_present[w_pad]     <= (r_sync2[3:2] == 2'b00);
          r_shadow[w_pad][7:6] <= {w_act[5], w_act[4]};
        end
        3'd5: begin
          r_six[w_pad] <= r_present[w_pad] && (r_sync2[3:0] == 4'b0000);
        end
        3'd6: begin
          r_shadow[w_pad][11:8] <= {w_act[0], w_act[1], w_act[2], w_act[3]};
        end
        default: begin
        end
      endcase
    end
  end

  function automatic logic [15:0] f_visible(input logic [11:0] sh, input logic pres, input logic six);
    if (!pres) begin
      return 16'h0000;
    end
    return {4'b0000, (six ? sh[11:8] : 4'b0000), sh[7:0]};
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1       <= '0;
      r_joy2       <= '0;
      r_presentOut <= '0;
      r_sixOut     <= '0;
      r_frameDone  <= 1'b0;
    end else begin
      r_frameDone <= w_frameEnd;
      if (w_frameEnd) begin
        r_joy1       <= f_visible(r_shadow[0], r_present[0], r_six[0]);
        r_joy2       <= f_visible(r_shadow[1], r_present[1], r_six[1]);
        r_presentOut <= r_present;
        r_sixOut     <= r_six & r_present;
      end
    end
  end

  assign joy_mdsel   = r_mdsel;
  assign joy_split   = r_split;
  assign joystick1   = r_joy1;
  assign joystick2   = r_joy2;
  assign pad_present = r_presentOut;
  assign six_btn     = r_sixOut;
  assign frame_done  = r_frameDone;

endmodule

// File: tb/tb_db9md_pad_scan.sv
`timescale 1ns/1ps
// tb_db9md_pad_scan: drives db9md_pad_scan with a behavioural pair of Megadrive pads
// and checks the published vectors against per-frame expectations.

module tb_db9md_pad_scan;

  localparam int HALF  = 4;
  localparam int IDLE  = 2;
  localparam int FRAME = (IDLE + 8) * 2 * HALF;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad_present;
  logic [1:0]  six_btn;
  logic        frame_done;

  bit          pres1 = 1'b0;
  bit          six1  = 1'b0;
  logic [11:0] btn1  = 12'h000;
  bit          pres2 = 1'b0;
  bit          six2  = 1'b0;
  logic [11:0] btn2  = 12'h000;

  int  fallCount = 0;
  time lastRise  = 0;
  int  checks    = 0;
  int  passes    = 0;

  db9md_pad_scan #(
    .HALF_CLKS  (HALF),
    .IDLE_PHASES(IDLE)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .joy_in     (joy_in),
    .joy_mdsel  (joy_mdsel),
    .joy_split  (joy_split),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .pad_present(pad_present),
    .six_btn    (six_btn),
    .frame_done (frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad step = number of select transitions since the select line sat high long enough to time out.
  always @(posedge joy_mdsel) lastRise = $time;
  always @(negedge joy_mdsel) begin
    if ($time - lastRise >= 150) fallCount = 1;
    else fallCount = fallCount + 1;
  end

  // Button word layout: 0 R,1 L,2 D,3 U,4 B,5 C,6 A,7 Start,8 Mode,9 X,10 Y,11 Z (active-high).
  function automatic logic [5:0] padOut(input bit pres, input bit six, input logic [11:0] b, input int step);
    logic u, d, l, r, bb, c, a, s, m, x, y, z;
    r = b[0]; l = b[1]; d = b[2]; u = b[3]; bb = b[4]; c = b[5];
    a = b[6]; s = b[7]; m = b[8]; x = b[9]; y = b[10]; z = b[11];
    if (!pres) return 6'b111111;
    if (step % 2 == 0) begin
      if (six && step == 6) return ~{c, bb, m, x, y, z};
      return ~{c, bb, r, l, d, u};
    end
    if (six && step == 5) return {~s, ~a, 4'b0000};
    return {~s, ~a, 2'b00, ~d, ~u};
  endfunction

  assign joy_in = joy_split ?
                  padOut(pres1, six1, btn1, joy_mdsel ? 2 * fallCount : 2 * fallCount - 1) :
                  padOut(pres2, six2, btn2, joy_mdsel ? 2 * fallCount : 2 * fallCount - 1);

  function automatic logic [15:0] expJoy(input bit pres, input bit six, input logic [11:0] b);
    if (!pres) return 16'h0000;
    if (six) return {4'h0, b};
    return {8'h00, b[7:0]};
  endfunction

  task automatic waitFrameDone(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_sys);
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({joy_mdsel, joy_split} !== 2'b11)
      $display("[TB] FAIL reset_select: got %b expected 11", {joy_mdsel, joy_split});
    else passes++;
    checks++;
    if ({joystick1, joystick2, pad_present, six_btn, frame_done} !== 37'd0)
      $display("[TB] FAIL reset_outputs: got %h expected 0", {joystick1, joystick2, pad_present, six_btn, frame_done});
    else passes++;
    reset_n = 1'b1;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (n != FRAME) $display("[TB] FAIL first_frame_latency: got %0d expected %0d", n, FRAME);
    else passes++;
  endtask

  task automatic test_absent();
    int n;
    pres1 = 0; pres2 = 0;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (n != FRAME) $display("[TB] FAIL absent_period: got %0d expected %0d", n, FRAME);
    else passes++;
    checks++;
    if ({joystick1, joystick2, pad_present, six_btn} !== 36'd0)
      $display("[TB] FAIL absent_outputs: got %h expected 0", {joystick1, joystick2, pad_present, six_btn});
    else passes++;
  endtask

  task automatic test_three_button();
    int n;
    pres1 = 1; six1 = 0; btn1 = 12'h041;
    pres2 = 1; six2 = 0; btn2 = 12'h088;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (n != FRAME) $display("[TB] FAIL three_period: got %0d expected %0d", n, FRAME);
    else passes++;
    checks++;
    if (joystick1 !== 16'h0041) $display("[TB] FAIL three_joy1: got %h expected 0041", joystick1);
    else passes++;
    checks++;
    if (joystick2 !== 16'h0088) $display("[TB] FAIL three_joy2: got %h expected 0088", joystick2);
    else passes++;
    checks++;
    if ({pad_present, six_btn} !== 4'b1100)
      $display("[TB] FAIL three_flags: got %b expected 1100", {pad_present, six_btn});
    else passes++;
  endtask

  task automatic test_six_button();
    int n;
    pres1 = 1; six1 = 1; btn1 = 12'h920;
    pres2 = 1; six2 = 0; btn2 = 12'h000;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (joystick1 !== 16'h0920) $display("[TB] FAIL six_joy1: got %h expected 0920", joystick1);
    else passes++;
    checks++;
    if (joystick2 !== 16'h0000) $display("[TB] FAIL six_joy2: got %h expected 0000", joystick2);
    else passes++;
    checks++;
    if ({pad_present, six_btn} !== 4'b1101)
      $display("[TB] FAIL six_flags: got %b expected 1101", {pad_present, six_btn});
    else passes++;
  endtask

  task automatic test_mid_frame_change();
    int n;
    pres1 = 1; six1 = 0; btn1 = 12'h010;
    pres2 = 0; six2 = 0; btn2 = 12'h000;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (joystick1 !== 16'h0010) $display("[TB] FAIL midchg_before: got %h expected 0010", joystick1);
    else passes++;
    repeat (2 * HALF * (IDLE + 3) + HALF) @(negedge clk_sys);
    checks++;
    if (joy_mdsel !== 1'b0) $display("[TB] FAIL midchg_in_p3: mdsel got %b expected 0", joy_mdsel);
    else passes++;
    btn1 = 12'h000;
    waitFrameDone(FRAME, n);
    checks++;
    if (n != FRAME - (2 * HALF * (IDLE + 3) + HALF))
      $display("[TB] FAIL midchg_remaining: got %0d expected %0d", n, FRAME - (2 * HALF * (IDLE + 3) + HALF));
    else passes++;
    checks++;
    if (joystick1 !== 16'h0010) $display("[TB] FAIL midchg_same_frame: got %h expected 0010", joystick1);
    else passes++;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (joystick1 !== 16'h0000) $display("[TB] FAIL midchg_next_frame: got %h expected 0000", joystick1);
    else passes++;
  endtask

  task automatic test_waveform();
    int  n, mToggles, sToggles, firstM, firstS, lastS;
    bit  idleHeld, spacingOk, firstMLow, fdEnd;
    logic prevM, prevS;
    waitFrameDone(FRAME + 20, n);
    idleHeld = (joy_mdsel === 1'b1) && (joy_split === 1'b1);
    prevM = joy_mdsel; prevS = joy_split;
    mToggles = 0; sToggles = 0; firstM = -1; firstS = -1; lastS = -1;
    spacingOk = 1; firstMLow = 0; fdEnd = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk_sys);
      if (i < 2 * HALF * IDLE && (joy_mdsel !== 1'b1 || joy_split !== 1'b1)) idleHeld = 0;
      if (joy_mdsel !== prevM) begin
        mToggles++;
        if (firstM < 0) begin
          firstM = i;
          firstMLow = (joy_mdsel === 1'b0);
        end
      end
      if (joy_split !== prevS) begin
        sToggles++;
        if (firstS < 0) firstS = i;
        else if (i - lastS != HALF) spacingOk = 0;
        lastS = i;
      end
      prevM = joy_mdsel; prevS = joy_split;
      if (i == FRAME) fdEnd = (frame_done === 1'b1);
    end
    checks++;
    if (!idleHeld) $display("[TB] FAIL wave_idle_held: got 0 expected 1");
    else passes++;
    checks++;
    if (mToggles != 8) $display("[TB] FAIL wave_mdsel_toggles: got %0d expected 8", mToggles);
    else passes++;
    checks++;
    if (firstM != 2 * HALF * (IDLE + 1) || !firstMLow)
      $display("[TB] FAIL wave_mdsel_start: got %0d/%0d expected %0d/1", firstM, firstMLow, 2 * HALF * (IDLE + 1));
    else passes++;
    checks++;
    if (sToggles != 16) $display("[TB] FAIL wave_split_toggles: got %0d expected 16", sToggles);
    else passes++;
    checks++;
    if (firstS != 2 * HALF * IDLE + HALF || !spacingOk)
      $display("[TB] FAIL wave_split_spacing: got %0d/%0d expected %0d/1", firstS, spacingOk, 2 * HALF * IDLE + HALF);
    else passes++;
    checks++;
    if (!fdEnd) $display("[TB] FAIL wave_period: got 0 expected frame_done at %0d", FRAME);
    else passes++;
  endtask

  task automatic test_random();
    int n, kind1, kind2;
    logic [15:0] e1, e2;
    for (int f = 0; f < 8; f++) begin
      kind1 = $urandom_range(0, 2);
      kind2 = $urandom_range(0, 2);
      btn1 = 12'($urandom);
      btn2 = 12'($urandom);
      if (kind1 == 1 && btn1[3] && btn1[2]) btn1[2] = 1'b0;
      if (kind2 == 1 && btn2[3] && btn2[2]) btn2[2] = 1'b0;
      pres1 = (kind1 != 0); six1 = (kind1 == 2);
      pres2 = (kind2 != 0); six2 = (kind2 == 2);
      e1 = expJoy(pres1, six1, btn1);
      e2 = expJoy(pres2, six2, btn2);
      waitFrameDone(FRAME + 20, n);
      checks++;
      if (n != FRAME) $display("[TB] FAIL rand_period[%0d]: got %0d expected %0d", f, n, FRAME);
      else passes++;
      checks++;
      if (joystick1 !== e1) $display("[TB] FAIL rand_joy1[%0d]: got %h expected %h", f, joystick1, e1);
      else passes++;
      checks++;
      if (joystick2 !== e2) $display("[TB] FAIL rand_joy2[%0d]: got %h expected %h", f, joystick2, e2);
      else passes++;
      checks++;
      if ({pad_present, six_btn} !== {pres2, pres1, pres2 & six2, pres1 & six1})
        $display("[TB] FAIL rand_flags[%0d]: got %b expected %b", f, {pad_present, six_btn},
                 {pres2, pres1, pres2 & six2, pres1 & six1});
      else passes++;
    end
  endtask

  task automatic test_mid_scan_reset();
    int n;
    pres1 = 1; six1 = 0; btn1 = 12'h041;
    pres2 = 1; six2 = 0; btn2 = 12'h088;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (joystick1 !== 16'h0041) $display("[TB] FAIL rst_precondition: got %h expected 0041", joystick1);
    else passes++;
    repeat (2 * HALF * (IDLE + 3) + 2) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({joy_mdsel, joy_split, joystick1, joystick2, pad_present, six_btn, frame_done} !== {2'b11, 37'd0})
      $display("[TB] FAIL rst_async: got %h expected %h",
               {joy_mdsel, joy_split, joystick1, joystick2, pad_present, six_btn, frame_done}, {2'b11, 37'd0});
    else passes++;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    waitFrameDone(FRAME + 20, n);
    checks++;
    if (n != FRAME) $display("[TB] FAIL rst_restart_latency: got %0d expected %0d", n, FRAME);
    else passes++;
    checks++;
    if ({joystick1, joystick2} !== {16'h0041, 16'h0088})
      $display("[TB] FAIL rst_restart_values: got %h expected 00410088", {joystick1, joystick2});
    else passes++;
  endtask

  initial begin
    $display("[TB] starting db9md_pad_scan bench");
    test_reset();
    test_absent();
    test_three_button();
    test_six_button();
    test_mid_frame_change();
    test_waveform();
    test_random();
    test_mid_scan_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/db9md_pad_scan.md
DB9MD_PAD_SCAN -- requirements
Module: db9md_pad_scan

Interface
REQ-001 Parameter HALF_CLKS, default 150: clk_sys cycles per half-phase; legal range is 4 or more.
REQ-002 Parameter IDLE_PHASES, default 256: number of idle phases between scan frames, so the pad's 6-button counter times out.
REQ-003 clk_sys  in  1  system clock, 35-50 MHz; one clock; all logic on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 joy_in  in  6  shared DB9 lines, active-low: [0]=U, [1]=D, [2]=L, [3]=R, [4]=pin6 (B/A), [5]=pin9 (C/Start).
REQ-006 joy_mdsel  out  1  Megadrive select line, driven to both pads.
REQ-007 joy_split  out  1  external mux select: 1 reads pad 1, 0 reads pad 2.
REQ-008 joystick1, joystick2  out  16 each  active-high buttons: 0 R, 1 L, 2 D, 3 U, 4 B, 5 C, 6 A, 7 Start, 8 Mode, 9 X, 10 Y, 11 Z; bits 15:12 are 0.
REQ-009 pad_present  out  2  bit0 is pad 1 and bit1 is pad 2; 1 means a Megadrive pad was detected in the last frame.
REQ-010 six_btn  out  2  1 means a 6-button pad was detected in the last frame.
REQ-011 frame_done  out  1  one-cycle pulse when all outputs update.

Function
REQ-012 joy_in SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 The FSM SHALL have two states: IDLE and SCAN.
REQ-014 One phase SHALL be 2*HALF_CLKS cycles.
  - First half: joy_split=1.
  - Second half: joy_split=0.
REQ-015 Pad 1 SHALL be sampled on the last cycle of the first half; pad 2 on the last cycle of the second half.
REQ-016 In SCAN, phase index p SHALL run 0..7, with joy_mdsel=1 when p is even and 0 when p is odd.
REQ-017 Per pad, with inputs inverted to active-high:
  - p0: capture U, D, L, R, B=[4], C=[5].
  - p1: present = (raw L,R both 0); capture A=[4], Start=[5].
  - p5: six = present AND raw [3:0]==0000.
  - p6: capture Z=[0], Y=[1], X=[2], Mode=[3].
  - p2, p3, p4, p7: no capture.
REQ-018 Captures SHALL go to shadow registers; visible outputs SHALL change only at frame end.
REQ-019 At the end of p7, for each pad:
  - If present=0: joystick=0 and six_btn=0.
  - If present=1 and six=0: bits 11:8 forced 0.
  - Otherwise: full shadow value.
  - frame_done SHALL pulse on the same cycle the outputs update.
REQ-020 After p7 the FSM SHALL enter IDLE for IDLE_PHASES phases, with joy_mdsel=1 and joy_split=1 held; then SCAN at p0.
REQ-021 Frame period SHALL be exactly (8+IDLE_PHASES)*2*HALF_CLKS cycles; frame_done SHALL recur with that period.
REQ-022 Output updates SHALL be atomic: no partially updated vector SHALL ever appear.
REQ-023 joy_in changes mid-frame SHALL affect only captures at later sample points.
REQ-024 Counters SHALL wrap only through explicit terminal-count compares; no free-running overflow.

Reset
REQ-025 While reset_n=0, outputs SHALL be held at:
  - joy_mdsel=1, joy_split=1.
  - joystick1=joystick2=0, pad_present=0, six_btn=0, frame_done=0.
  - Internally: FSM in IDLE, all counters 0, shadows 0, synchronizer flops at 6'b111111.
REQ-026 Reset assertion mid-SCAN SHALL abort immediately with no output update.
REQ-027 After release, the first SCAN SHALL begin after a full IDLE_PHASES idle period.
REQ-028 The first frame_done SHALL occur exactly (IDLE_PHASES+8)*2*HALF_CLKS cycles after the first clk_sys edge following release.

Verification (bench setup: HALF_CLKS=4, IDLE_PHASES=2, Megadrive pad model driven by joy_mdsel/joy_split)
REQ-029 Reset mid-SCAN at p3 -> outputs return to reset values asynchronously; the next frame_done occurs 80 cycles after release.
REQ-030 Both pads absent (joy_in=6'b111111 always) -> joystick1=joystick2=0, pad_present=00; frame_done period is 80 cycles.
REQ-031 3-button pad 1 holding A+Right, pad 2 holding Start+Up -> joystick1=16'h0041, joystick2=16'h0088, pad_present=11, six_btn=00.
REQ-032 6-button pad 1 holding Z+Mode+C -> joystick1=16'h0920, six_btn[0]=1; 3-button pad 2 with no keys -> joystick2=0, six_btn[1]=0.
REQ-033 Pad 1 changes from B to idle during p3 of a frame -> joystick1 bit4 stays 1 for that frame and clears on the next frame_done.
REQ-034 Waveform check -> joy_mdsel toggles 8 times per SCAN starting high; joy_split toggles every 4 cycles in SCAN and stays 1 in IDLE.
